// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode / operand-fetch slice:
//   - opcode constants for the supported instruction subset
//   - FSM state encoding for mips_decode_fetch
//   - instruction field bit positions
//   - immediate-extension kind and the per-opcode decode helper
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Supported opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JT_HI  = 25;
    localparam int JT_LO  = 0;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RF_REQ = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        IMM_SIGN = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_LUI  = 2'd2
    } imm_kind_t;

    // Per-instruction control derived from the opcode alone
    typedef struct packed {
        logic [4:0] dest;
        logic       reg_write;
        logic       use_imm;   // op_b takes imm_ext instead of the rt value
        logic       skip_rf;   // no register read needed (jumps, illegal)
        logic       illegal;
    } dec_t;

    function automatic imm_kind_t imm_kind(input logic [5:0] op);
        imm_kind_t k;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: k = IMM_ZERO;
            OP_LUI:                   k = IMM_LUI;
            default:                  k = IMM_SIGN;
        endcase
        return k;
    endfunction

    function automatic dec_t decode_op(input logic [5:0] op,
                                       input logic [4:0] rt,
                                       input logic [4:0] rd);
        dec_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                d.dest      = rd;
                d.reg_write = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                d.dest      = rt;
                d.reg_write = 1'b1;
                d.use_imm   = 1'b1;
            end
            OP_SW: begin
                d.use_imm   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.use_imm   = 1'b0;
            end
            OP_J: begin
                d.skip_rf   = 1'b1;
            end
            OP_JAL: begin
                d.dest      = REG_RA;
                d.reg_write = 1'b1;
                d.skip_rf   = 1'b1;
            end
            default: begin
                d.illegal   = 1'b1;
                d.skip_rf   = 1'b1;
            end
        endcase
        // $0 is hardwired to zero, so a write to it is never a write
        if (d.dest == 5'd0) begin
            d.reg_write = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/mips_imm_ext.sv
// -----------------------------------------------------------------------------
// mips_imm_ext
// Combinational immediate extender. Maps the 16-bit immediate to 32 bits
// according to the opcode: sign extension (default), zero extension for the
// logical immediates, or a 16-bit left shift for lui.
// Ports:
//   opcode   in  6   instruction opcode
//   imm      in  16  instruction immediate field
//   imm_ext  out 32  extended immediate
// -----------------------------------------------------------------------------
module mips_imm_ext
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [15:0] imm,
    output logic [31:0] imm_ext
);

    logic signed [15:0] imm_s;
    logic signed [31:0] imm_sx;

    assign imm_s  = imm;
    assign imm_sx = imm_s;

    always_comb begin
        imm_ext = imm_sx;
        case (imm_kind(opcode))
            IMM_ZERO: imm_ext = {16'h0000, imm};
            IMM_LUI:  imm_ext = {imm, 16'h0000};
            default:  imm_ext = imm_sx;
        endcase
    end

endmodule

// File: rtl/mips_decode_fetch.sv
// -----------------------------------------------------------------------------
// mips_decode_fetch
// Multicycle decode and operand-fetch stage in front of the rf_32 register
// file. One instruction is accepted per start, decoded, its source registers
// are read from rf_32, and the decoded control plus operands are presented
// with a one-cycle finish pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, instr             request and instruction word (taken in IDLE only)
//   rf_finish, rf_outA/B     rf_32 response and read data
//   rf_start                 rf_32 request
//   rf_read_addr_s/t         rs / rt addresses to rf_32
//   busy                     high outside IDLE
//   finish                   one-cycle pulse, outputs below valid
//   opcode, funct, shamt     raw instruction fields
//   dest_addr, reg_write     writeback register and write enable
//   op_a, op_b               rs value, second operand after the imm mux
//   imm_ext, jtarget         extended immediate, jump target field
//   illegal, rf_err          unsupported opcode, rf_32 timeout
// -----------------------------------------------------------------------------
module mips_decode_fetch
    import mips_pkg::*;
#(
    parameter int RF_TIMEOUT = 15,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic              rf_finish,
    input  logic [DATA_W-1:0] rf_outA,
    input  logic [DATA_W-1:0] rf_outB,
    output logic              rf_start,
    output logic [4:0]        rf_read_addr_s,
    output logic [4:0]        rf_read_addr_t,
    output logic              busy,
    output logic              finish,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        shamt,
    output logic [4:0]        dest_addr,
    output logic              reg_write,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [31:0]       imm_ext,
    output logic [25:0]       jtarget,
    output logic              illegal,
    output logic              rf_err
);

    localparam int             CNT_W    = $clog2(RF_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RF_TIMEOUT - 1);

    state_t             state;
    logic [31:0]        instr_q;
    logic [CNT_W-1:0]   cnt;
    logic               use_imm_q;

    logic [31:0]        imm_ext_d;
    dec_t               dec_d;

    assign dec_d = decode_op(instr_q[OPC_HI:OPC_LO],
                             instr_q[RT_HI:RT_LO],
                             instr_q[RD_HI:RD_LO]);

    mips_imm_ext u_imm_ext (
        .opcode  (instr_q[OPC_HI:OPC_LO]),
        .imm     (instr_q[IMM_HI:IMM_LO]),
        .imm_ext (imm_ext_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            instr_q        <= '0;
            cnt            <= '0;
            use_imm_q      <= 1'b0;
            rf_start       <= 1'b0;
            rf_read_addr_s <= '0;
            rf_read_addr_t <= '0;
            busy           <= 1'b0;
            finish         <= 1'b0;
            opcode         <= '0;
            funct          <= '0;
            shamt          <= '0;
            dest_addr      <= '0;
            reg_write      <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            imm_ext        <= '0;
            jtarget        <= '0;
            illegal        <= 1'b0;
            rf_err         <= 1'b0;
        end else begin
            // finish is only raised on the transition into DONE
            finish <= 1'b0;
            case (state)
                // ---- IDLE: accept a new instruction ----
                ST_IDLE: begin
                    if (start) begin
                        instr_q <= instr;
                        rf_err  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_DECODE;
                    end
                end

                // ---- DECODE: register fields and control ----
                ST_DECODE: begin
                    opcode         <= instr_q[OPC_HI:OPC_LO];
                    funct          <= instr_q[FN_HI:FN_LO];
                    shamt          <= instr_q[SH_HI:SH_LO];
                    jtarget        <= instr_q[JT_HI:JT_LO];
                    rf_read_addr_s <= instr_q[RS_HI:RS_LO];
                    rf_read_addr_t <= instr_q[RT_HI:RT_LO];
                    dest_addr      <= dec_d.dest;
                    reg_write      <= dec_d.reg_write;
                    illegal        <= dec_d.illegal;
                    imm_ext        <= dec_d.illegal ? 32'h0 : imm_ext_d;
                    use_imm_q      <= dec_d.use_imm;
                    op_a           <= '0;
                    op_b           <= '0;
                    cnt            <= '0;
                    if (dec_d.skip_rf) begin
                        finish <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        rf_start <= 1'b1;
                        state    <= ST_RF_REQ;
                    end
                end

                // ---- RF_REQ: wait for rf_32, bounded by RF_TIMEOUT ----
                ST_RF_REQ: begin
                    if (rf_finish) begin
                        op_a     <= rf_outA;
                        op_b     <= use_imm_q ? imm_ext : rf_outB;
                        rf_start <= 1'b0;
                        finish   <= 1'b1;
                        state    <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rf_err   <= 1'b1;
                        op_a     <= '0;
                        op_b     <= '0;
                        rf_start <= 1'b0;
                        finish   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // ---- DONE: finish is high this cycle, return to IDLE ----
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_decode_fetch.md
Name: mips_decode_fetch

Overview:
- Multicycle decode and operand-fetch stage, directly upstream of the rf_32 register file.
- Accepts one MIPS instruction word per start/finish handshake and decodes its fields.
- Drives rf_32 read addresses and start, waits for rf_32 finish, then captures outA/outB.
- Presents decoded control and operands to the downstream ALU stage.

Parameters:
- RF_TIMEOUT, 15: maximum cycles to wait for rf_finish before aborting with rf_err.
- DATA_W, 32: datapath width. Fixed at 32; present for documentation only.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to decode instr; sampled only in IDLE.
- instr  in  32  instruction word; captured on the accepted start.
- rf_finish  in  1  rf_32 finish.
- rf_outA  in  32  rf_32 outA (value at read_addr_s).
- rf_outB  in  32  rf_32 outB (value at read_addr_t).
- rf_start  out  1  rf_32 start.
- rf_read_addr_s  out  5  rs field to rf_32.
- rf_read_addr_t  out  5  rt field to rf_32.
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle pulse when the outputs below are valid.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- shamt  out  5  instr[10:6].
- dest_addr  out  5  writeback register.
- reg_write  out  1  instruction writes dest_addr.
- op_a  out  32  rs value.
- op_b  out  32  second operand, after the operand mux.
- imm_ext  out  32  extended immediate.
- jtarget  out  26  instr[25:0].
- illegal  out  1  opcode is not in the supported set.
- rf_err  out  1  rf_32 did not respond within RF_TIMEOUT cycles.

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE. rst mid-operation returns to IDLE on the next edge, drops rf_start, and produces no finish pulse.
- FSM states: IDLE, DECODE, RF_REQ, DONE.
- IDLE:
  - start=1 latches instr and moves to DECODE.
  - start in any other state is ignored; it is not queued.
- DECODE (1 cycle):
  - Register all field outputs, imm_ext, dest_addr, reg_write and illegal.
  - Drive rf_read_addr_s=instr[25:21] and rf_read_addr_t=instr[20:16]. Both stay stable until the next accepted start.
  - illegal=1 or opcode j (0x02) or jal (0x03) -> DONE, no register read, op_a=op_b=0.
  - Otherwise -> RF_REQ.
- RF_REQ:
  - rf_start=1 and a timeout counter increments each cycle.
  - rf_finish=1 sampled: capture op_a=rf_outA, op_b=mux(rf_outB, imm_ext); drop rf_start; go to DONE.
  - Counter reaches RF_TIMEOUT with no rf_finish: rf_err=1, op_a=op_b=0, drop rf_start, go to DONE.
- DONE: finish=1 for exactly one cycle, then IDLE. All data outputs hold until the next accepted start.
- Minimum latency, start accepted to finish: 3 cycles when rf_finish is already high.
- Decode rules:
  - R-type (0x00): dest=rd, reg_write=1, op_b=rt value.
  - addi 08, addiu 09, slti 0A, sltiu 0B: sign-extended immediate, dest=rt, reg_write=1, op_b=imm_ext.
  - andi 0C, ori 0D, xori 0E: zero-extended immediate, otherwise as above.
  - lui 0F: imm_ext={imm,16'h0}, dest=rt, reg_write=1.
  - lw 23: sign-extended immediate, dest=rt, reg_write=1, op_b=imm_ext.
  - sw 2B: sign-extended immediate, op_b=imm_ext, reg_write=0. The store data is rt, and it is not exported in this revision.
  - beq 04, bne 05: op_b=rt value, imm_ext sign-extended, reg_write=0.
  - j 02: reg_write=0.
  - jal 03: dest=31, reg_write=1.
- reg_write is forced to 0 whenever dest_addr==0.
- illegal forces reg_write=0 and imm_ext=0.
- rf_err clears on the next accepted start.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, ... OP_JAL);
  - FSM state encoding;
  - field bit-position constants.
- One natural sub-module: mips_imm_ext. It is combinational and maps opcode and imm[15:0] to imm_ext: sign, zero, or lui shift.

Test Plan:
- Reset: hold rst 2 cycles while start=1 -> all outputs 0, busy=0, no finish pulse.
- R-type 0x00430820 (add $1,$2,$3), rf model returns outA=0x11111111, outB=0x22222222 after 1 cycle -> read_addr_s=2, read_addr_t=3, dest_addr=1, reg_write=1, op_a=0x11111111, op_b=0x22222222, one finish pulse.
- addi 0x2041FFFF -> imm_ext=0xFFFFFFFF, op_b=0xFFFFFFFF. ori 0x3441FFFF -> imm_ext=0x0000FFFF. lui 0x3C01ABCD -> imm_ext=0xABCD0000, dest_addr=1.
- jal 0x0C000100 -> no rf_start ever asserted, dest_addr=31, reg_write=1, jtarget=0x0000100, finish at 2 cycles. addi to $0 (0x20000005) -> reg_write=0.
- rf_finish held 0 -> rf_err=1 after exactly RF_TIMEOUT=15 RF_REQ cycles, op_a=op_b=0, finish pulse. Next start clears rf_err.
- Opcode 0x3F -> illegal=1, reg_write=0. Start pulsed during RF_REQ is ignored. rst asserted in RF_REQ -> IDLE next edge, rf_start=0, no finish.
